led_row_driver: RTL
===================

Name: led_row_driver

Overview:
- Consumer end of the `rgb_row_t` row interface produced by the pattern generators (hscan and similar).
- Accepts one `rgb_row_t` per valid/ready handshake and buffers it internally.
- Serialises the buffered row onto the HUB75-style panel pins: six colour lines, shift clock, latch, output enable and row address.
- Sits between the pattern/frame logic and the top-level panel IO.

Parameters:
- CLK_DIV, 2, half-period of `sclk_out` in `clk_in` cycles (≥1).
- NUM_ROWS, 16, number of scan rows (addressed rows per half-panel, ≥2).
- BLANK_CYCLES, 4, cycles with `n_oe_out` high before latch (≥1).
- LATCH_CYCLES, 2, cycles `latch_out` is held high (≥1).
- DISPLAY_CYCLES, 1000, cycles with `n_oe_out` low after latch (≥1).
- ADDR_W = $clog2(NUM_ROWS), derived localparam; not user-set.

Ports:
- clk_in  input  1  system clock
- n_reset_in  input  1  asynchronous active-low reset
- row_in  input  rgb_row_t  row pixel data (top/bot × red/green/blue, GL_NUM_COL_PIXELS bits each)
- row_valid_in  input  1  row_in valid
- row_ready_out  output  1  driver can accept a row
- r0_out, g0_out, b0_out  output  1 each  top-half colour serial data
- r1_out, g1_out, b1_out  output  1 each  bottom-half colour serial data
- sclk_out  output  1  panel shift clock
- latch_out  output  1  panel latch strobe
- n_oe_out  output  1  panel output enable, active low
- addr_out  output  ADDR_W  panel row address
- frame_start_out  output  1  one-cycle pulse when addr_out wraps to 0

Behaviour:
- Reset: asynchronous on `n_reset_in` low, regardless of state.
  - Outputs: `row_ready_out`=0, colour outputs=0, `sclk_out`=0, `latch_out`=0, `n_oe_out`=1 (blanked), `addr_out`=0, `frame_start_out`=0.
  - Internal state: FSM=IDLE, column counter=0, row counter=0; any row in flight is discarded.
  - First cycle after reset release: `row_ready_out`=1.
- FSM states: IDLE → SHIFT → BLANK → LATCH → DISPLAY → IDLE. All outputs are registered.
- IDLE:
  - `row_ready_out`=1, `n_oe_out`=1.
  - Capture occurs on the rising edge where `row_valid_in`&&`row_ready_out`. `row_in` is copied into the internal buffer; next state is SHIFT and `row_ready_out` drops to 0.
  - `row_valid_in` while `row_ready_out`=0 is ignored. Upstream must hold the row; `row_in` changes are invisible after capture.
- SHIFT, N = GL_NUM_COL_PIXELS columns:
  - Columns are shifted MSB first (index N-1 first, index 0 last).
  - Each column is 2×CLK_DIV cycles: colour outputs are set to the column bits with `sclk_out`=0 for CLK_DIV cycles, then `sclk_out`=1 for CLK_DIV cycles.
  - Colour data changes only on the cycle `sclk_out` goes low; it is stable across every `sclk_out` rising edge.
  - Mapping: top.red→r0, top.green→g0, top.blue→b0, bot.red→r1, bot.green→g1, bot.blue→b1.
  - Total duration N×2×CLK_DIV cycles. On exit `sclk_out`=0 and colour outputs return to 0.
  - `n_oe_out` stays 1 throughout SHIFT.
- BLANK:
  - Lasts BLANK_CYCLES cycles with `n_oe_out`=1.
  - On the first BLANK cycle, `addr_out` takes the row counter value.
- LATCH: `latch_out`=1 for LATCH_CYCLES cycles, `n_oe_out`=1.
- DISPLAY:
  - `n_oe_out`=0 for DISPLAY_CYCLES cycles.
  - On exit the row counter increments, wrapping from NUM_ROWS-1 to 0, and the FSM returns to IDLE.
- `frame_start_out`:
  - One-cycle pulse in the first BLANK cycle whenever `addr_out` is loaded with 0.
  - This includes the first row after reset.
- Minimum row period: 1 (capture) + N×2×CLK_DIV + BLANK_CYCLES + LATCH_CYCLES + DISPLAY_CYCLES cycles.
- Counters are sized to hold their maximum parameter value; no overflow is possible.

Test Plan:
- Reset, then a single row with N=64, CLK_DIV=2, top.red=64'h8000_0000_0000_0001, all other colours 0 → r0_out=1 for the first column only (cycles 1–4 after capture) and the last column only; exactly 64 `sclk_out` rising edges; `latch_out` pulses 2 cycles; `n_oe_out` low for 1000 cycles; `addr_out`=0; `frame_start_out` pulses once.
- Back-to-back: hold `row_valid_in`=1 with 17 rows, NUM_ROWS=16 → `addr_out` sequence 0..15,0; `frame_start_out` pulses on rows 1 and 17; `row_ready_out` is high for exactly one cycle between rows.
- Drive `row_valid_in` and toggle `row_in` during SHIFT → no capture occurs and the shifted data equals the originally captured row.
- Full colour check: top={R=A5..,G=5A..,B=FF..}, bot={R=0,G=FF..,B=3C..} → the bench samples all six lines on each `sclk_out` rising edge and reconstructs both halves exactly.
- Assert `n_reset_in` low mid-SHIFT (column 20) → same cycle `n_oe_out`=1, `sclk_out`=0, `addr_out`=0. After release the next row starts at column N-1, and `frame_start_out` pulses.
- CLK_DIV=1, BLANK_CYCLES=1, LATCH_CYCLES=1, DISPLAY_CYCLES=1 → row period is exactly 1+2N+3 cycles, and `latch_out` never overlaps `n_oe_out`=0.

Source files
------------

// File: rtl/led_row_driver_pkg.sv
// Shared row payload types passed from the pattern generators to the panel driver.
package led_row_driver_pkg;

    localparam int unsigned GL_NUM_COL_PIXELS = 64;

    // One colour plane per primary, one bit per column.
    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] red;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] blue;
    } rgb_t;

    // Top and bottom half-panel rows driven in the same scan slot.
    typedef struct packed {
        rgb_t top;
        rgb_t bot;
    } rgb_row_t;

endpackage

// File: rtl/led_row_driver.sv
// HUB75 row driver: captures one rgb_row_t per handshake, shifts it out MSB
// column first, then blanks, latches and displays it on the addressed row.
module led_row_driver
    import led_row_driver_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned NUM_ROWS       = 16,
    parameter int unsigned BLANK_CYCLES   = 4,
    parameter int unsigned LATCH_CYCLES   = 2,
    parameter int unsigned DISPLAY_CYCLES = 1000,
    localparam int unsigned ADDR_W        = $clog2(NUM_ROWS)
) (
    input  logic              clk_in,
    input  logic              n_reset_in,
    input  rgb_row_t          row_in,
    input  logic              row_valid_in,
    output logic              row_ready_out,
    output logic              r0_out,
    output logic              g0_out,
    output logic              b0_out,
    output logic              r1_out,
    output logic              g1_out,
    output logic              b1_out,
    output logic              sclk_out,
    output logic              latch_out,
    output logic              n_oe_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              frame_start_out
);

    localparam int unsigned N         = GL_NUM_COL_PIXELS;
    localparam int unsigned COL_W     = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SHIFT_LEN = 2 * CLK_DIV;
    localparam int unsigned MAX_BL    = (BLANK_CYCLES > LATCH_CYCLES) ? BLANK_CYCLES : LATCH_CYCLES;
    localparam int unsigned MAX_DS    = (DISPLAY_CYCLES > SHIFT_LEN) ? DISPLAY_CYCLES : SHIFT_LEN;
    localparam int unsigned CNT_MAX   = (MAX_BL > MAX_DS) ? MAX_BL : MAX_DS;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t            state;
    rgb_row_t          row_buf;
    logic [COL_W-1:0]  col_idx;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] row_cnt;
    logic [5:0]        colour_q;

    // Six colour bits of one column, ordered r0 g0 b0 r1 g1 b1.
    function automatic logic [5:0] col_bits(input rgb_row_t r, input logic [COL_W-1:0] i);
        return {r.top.red[i], r.top.green[i], r.top.blue[i],
                r.bot.red[i], r.bot.green[i], r.bot.blue[i]};
    endfunction

    assign {r0_out, g0_out, b0_out, r1_out, g1_out, b1_out} = colour_q;

    // Scan sequencer: every panel pin is produced directly from this register stage.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state           <= S_IDLE;
            row_buf         <= '0;
            col_idx         <= '0;
            cnt             <= '0;
            row_cnt         <= '0;
            row_ready_out   <= 1'b0;
            colour_q        <= '0;
            sclk_out        <= 1'b0;
            latch_out       <= 1'b0;
            n_oe_out        <= 1'b1;
            addr_out        <= '0;
            frame_start_out <= 1'b0;
        end else begin
            frame_start_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    n_oe_out <= 1'b1;
                    if (row_ready_out && row_valid_in) begin
                        // First column goes out straight from row_in so shifting starts next cycle.
                        row_buf       <= row_in;
                        row_ready_out <= 1'b0;
                        col_idx       <= COL_W'(N - 1);
                        cnt           <= '0;
                        colour_q      <= col_bits(row_in, COL_W'(N - 1));
                        sclk_out      <= 1'b0;
                        state         <= S_SHIFT;
                    end else begin
                        row_ready_out <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        sclk_out <= 1'b1;
                        cnt      <= cnt + CNT_W'(1);
                    end else if (cnt == CNT_W'(SHIFT_LEN - 1)) begin
                        cnt      <= '0;
                        sclk_out <= 1'b0;
                        if (col_idx == '0) begin
                            colour_q        <= '0;
                            addr_out        <= row_cnt;
                            frame_start_out <= (row_cnt == '0);
                            state           <= S_BLANK;
                        end else begin
                            col_idx  <= col_idx - COL_W'(1);
                            colour_q <= col_bits(row_buf, col_idx - COL_W'(1));
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_BLANK: begin
                    if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                        cnt       <= '0;
                        latch_out <= 1'b1;
                        state     <= S_LATCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_LATCH: begin
                    // Latch falls on the same edge the display enables, so they never overlap.
                    if (cnt == CNT_W'(LATCH_CYCLES - 1)) begin
                        cnt       <= '0;
                        latch_out <= 1'b0;
                        n_oe_out  <= 1'b0;
                        state     <= S_DISPLAY;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DISPLAY: begin
                    if (cnt == CNT_W'(DISPLAY_CYCLES - 1)) begin
                        cnt           <= '0;
                        n_oe_out      <= 1'b1;
                        row_ready_out <= 1'b1;
                        row_cnt       <= (row_cnt == ADDR_W'(NUM_ROWS - 1)) ? '0 : row_cnt + ADDR_W'(1);
                        state         <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
